// File: rtl/cipher_pkg.sv
// Shared constants, types and helpers for the nibble cipher.
// Single source of the S-box for key_schedule and sbox.
package cipher_pkg;

  localparam int NIBW = 4;

  // S(x) for x = 0..F, packed with x = 0 in the top nibble.
  localparam logic [63:0] SBOX = 64'hE4D1_2FB8_3A6C_5907;

  typedef enum logic {
    IDLE,
    EMIT
  } ks_state_t;

  function automatic logic [NIBW-1:0] sub_nib(
    input logic [NIBW-1:0] x
  );
    logic [5:0] base;
    base = 6'(15 - int'(x)) << 2;
    return SBOX[base +: NIBW];
  endfunction

  // Multiply by x in GF(2^4), reduction polynomial x^4 + x + 1.
  function automatic logic [NIBW-1:0] xtime(
    input logic [NIBW-1:0] a
  );
    logic [NIBW-1:0] s;
    s = {a[2:0], 1'b0};
    if (a[3]) s = s ^ 4'h3;
    return s;
  endfunction

  // rcon(1) = 1, rcon(r+1) = xtime(rcon(r)).
  function automatic logic [NIBW-1:0] rcon(
    input logic [NIBW-1:0] r
  );
    logic [NIBW-1:0] c;
    c = 4'h1;
    for (int i = 2; i < 16; i++) begin
      if (i <= int'(r)) c = xtime(c);
    end
    return c;
  endfunction

endpackage

// File: rtl/key_expand_step.sv
// One key-expansion step: (key, rc) -> next round key.
// Ports: key_i (16b), rc_i (4b) in; key_o (16b) out. Combinational.
module key_expand_step
  import cipher_pkg::*;
(
  input  logic [15:0]     key_i,
  input  logic [NIBW-1:0] rc_i,
  output logic [15:0]     key_o
);

  logic [NIBW-1:0] w0, w1, w2, w3;
  logic [NIBW-1:0] w4, w5, w6, w7;

  assign {w0, w1, w2, w3} = key_i;

  assign w4 = w0 ^ sub_nib(w3) ^ rc_i;
  assign w5 = w1 ^ w4;
  assign w6 = w2 ^ w5;
  assign w7 = w3 ^ w6;

  assign key_o = {w4, w5, w6, w7};

endmodule

// File: rtl/key_schedule.sv
// Sequential round-key generator: takes a master key, streams
// K0..KNROUNDS with index over valid/ready.
// Ports: clk_i, rst_ni (sync, active-low); key_valid_i/key_ready_o/key_i
// master key in; rk_valid_o/rk_ready_i/rk_o/rk_idx_o/rk_last_o keys out;
// busy_o high while streaming.
module key_schedule
  import cipher_pkg::*;
#(
  parameter int DATAW   = 16,
  parameter int NROUNDS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [DATAW-1:0] key_i,
  output logic             rk_valid_o,
  input  logic             rk_ready_i,
  output logic [DATAW-1:0] rk_o,
  output logic [3:0]       rk_idx_o,
  output logic             rk_last_o,
  output logic             busy_o
);

  localparam logic [3:0] LAST = 4'(NROUNDS);

  ks_state_t        state_q, state_d;
  logic [DATAW-1:0] key_q, key_d;
  logic [3:0]       idx_q, idx_d;
  logic [DATAW-1:0] next_key;
  logic [3:0]       idx_nx;

  assign idx_nx = idx_q + 4'd1;

  key_expand_step u_step (
    .key_i (key_q),
    .rc_i  (rcon(idx_nx)),
    .key_o (next_key)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    idx_d       = idx_q;
    key_ready_o = 1'b0;
    rk_valid_o  = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        key_ready_o = rst_ni;
        if (key_valid_i && rst_ni) begin
          state_d = EMIT;
          key_d   = key_i;
          idx_d   = '0;
        end
      end
      EMIT: begin
        rk_valid_o = 1'b1;
        busy_o     = 1'b1;
        if (rk_ready_i) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
          end else begin
            key_d = next_key;
            idx_d = idx_nx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rk_o      = key_q;
  assign rk_idx_o  = idx_q;
  assign rk_last_o = (state_q == EMIT) && (idx_q == LAST);

endmodule

// File: tb/tb_key_schedule.sv
// Directed self-checking bench for key_schedule.
// Expected keys are hand-expanded from the S-box and rcon tables.
module tb_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [15:0] key;
  logic        rk_valid;
  logic        rk_ready;
  logic [15:0] rk;
  logic [3:0]  rk_idx;
  logic        rk_last;
  logic        busy;

  int total;
  int bad;

  logic [15:0] exp0 [5];

  key_schedule #(
    .DATAW   (16),
    .NROUNDS (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .key_valid_i (key_valid),
    .key_ready_o (key_ready),
    .key_i       (key),
    .rk_valid_o  (rk_valid),
    .rk_ready_i  (rk_ready),
    .rk_o        (rk),
    .rk_idx_o    (rk_idx),
    .rk_last_o   (rk_last),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] k);
    key_valid = 1'b1;
    key       = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    rk_ready  = 1'b0;
    step();
    step();
    total++;
    if (key_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_low_ready got=%0b want=0", key_ready);
    end
    rst_n = 1'b1;
    step();
    total++;
    if ({key_ready, rk_valid, busy, rk_last} !== 4'b1000) begin
      bad++;
      $display("FAIL rst_flags got=%b want=1000",
               {key_ready, rk_valid, busy, rk_last});
    end
    total++;
    if (rk !== 16'h0000 || rk_idx !== 4'd0) begin
      bad++;
      $display("FAIL rst_key got=%h/%0d want=0000/0", rk, rk_idx);
    end
  endtask

  task automatic test_stream();
    rk_ready = 1'b1;
    load(16'h0000);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rk !== exp0[i] || rk_idx !== 4'(i) || rk_valid !== 1'b1 ||
          rk_last !== (i == 4) || busy !== 1'b1) begin
        bad++;
        $display("FAIL stream_%0d got=%h idx=%0d v=%0b l=%0b want=%h idx=%0d",
                 i, rk, rk_idx, rk_valid, rk_last, exp0[i], i);
      end
      step();
    end
    total++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stream_end got v=%0b r=%0b b=%0b want v=0 r=1 b=0",
               rk_valid, key_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    rk_ready = 1'b1;
    load(16'h0000);
    step();
    step();
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (rk !== 16'hA5A5 || rk_idx !== 4'd2 || rk_valid !== 1'b1 ||
          rk_last !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d got=%h idx=%0d v=%0b want=a5a5 idx=2 v=1",
                 i, rk, rk_idx, rk_valid);
      end
    end
    rk_ready = 1'b1;
    step();
    total++;
    if (rk !== 16'h14EB || rk_idx !== 4'd3) begin
      bad++;
      $display("FAIL bp_resume got=%h idx=%0d want=14eb idx=3", rk, rk_idx);
    end
    step();
    step();
    total++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_end got v=%0b r=%0b want v=0 r=1", rk_valid, key_ready);
    end
  endtask

  task automatic test_busy_ignore();
    rk_ready = 1'b1;
    load(16'h0000);
    key_valid = 1'b1;
    key       = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (key_ready !== 1'b0 || rk !== exp0[i] || rk_idx !== 4'(i)) begin
        bad++;
        $display("FAIL busy_%0d got=%h idx=%0d rdy=%0b want=%h idx=%0d rdy=0",
                 i, rk, rk_idx, key_ready, exp0[i], i);
      end
      if (i == 4) key_valid = 1'b0;
      step();
    end
    total++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL busy_end got v=%0b r=%0b want v=0 r=1", rk_valid, key_ready);
    end
  endtask

  task automatic test_mid_reset();
    rk_ready = 1'b1;
    load(16'h0000);
    step();
    total++;
    if (rk_idx !== 4'd1 || rk !== 16'hFFFF) begin
      bad++;
      $display("FAIL mrst_pre got=%h idx=%0d want=ffff idx=1", rk, rk_idx);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b0 ||
        rk !== 16'h0000 || rk_idx !== 4'd0) begin
      bad++;
      $display("FAIL mrst_state got v=%0b r=%0b b=%0b k=%h idx=%0d want 0 0 0 0000 0",
               rk_valid, key_ready, busy, rk, rk_idx);
    end
    rst_n = 1'b1;
    load(16'h0000);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rk !== exp0[i] || rk_idx !== 4'(i) || rk_valid !== 1'b1) begin
        bad++;
        $display("FAIL mrst_restart_%0d got=%h idx=%0d want=%h idx=%0d",
                 i, rk, rk_idx, exp0[i], i);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    rk_ready = 1'b1;
    load(16'h0000);
    key_valid = 1'b1;
    key       = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rk !== exp0[i] || rk_last !== (i == 4)) begin
        bad++;
        $display("FAIL b2b_first_%0d got=%h l=%0b want=%h", i, rk, rk_last, exp0[i]);
      end
      step();
    end
    total++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got r=%0b v=%0b want r=1 v=0", key_ready, rk_valid);
    end
    step();
    key_valid = 1'b0;
    total++;
    if (rk_valid !== 1'b1 || rk !== 16'hBEEF || rk_idx !== 4'd0) begin
      bad++;
      $display("FAIL b2b_k0 got v=%0b k=%h idx=%0d want v=1 k=beef idx=0",
               rk_valid, rk, rk_idx);
    end
    step();
    total++;
    if (rk !== 16'hD3D2 || rk_idx !== 4'd1) begin
      bad++;
      $display("FAIL b2b_k1 got=%h idx=%0d want=d3d2 idx=1", rk, rk_idx);
    end
    for (int i = 0; i < 4; i++) step();
    total++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end got v=%0b r=%0b want v=0 r=1", rk_valid, key_ready);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    exp0[0] = 16'h0000;
    exp0[1] = 16'hFFFF;
    exp0[2] = 16'hA5A5;
    exp0[3] = 16'h14EB;
    exp0[4] = 16'h51F4;
    test_reset();
    test_stream();
    test_backpressure();
    test_busy_ignore();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
